// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver (LSB first) presenting each received byte as
// one AXI-stream beat. Bit period is prescale*8 clk cycles (prescale 0 acts as 1),
// which matches the transmitter so the two loop back directly.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   m_axis_tdata/tvalid   received byte and its valid flag
//   m_axis_tready         downstream accept; never stalls reception
//   rxd                   asynchronous serial input, idle high
//   busy                  a frame (or a break after a bad stop bit) is in progress
//   overrun_error         1-cycle pulse: new byte replaced an unconsumed one
//   frame_error           1-cycle pulse: stop bit sampled low
//   prescale              bit-rate divider, latched at start detection
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  // Synchroniser plus one history flop for falling-edge detection.
  logic rxd_meta_q, rxd_s_q, rxd_prev_q;

  state_t                state_q, state_d;
  logic [18:0]           timer_q, timer_d;
  logic [15:0]           presc_q, presc_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  logic [15:0] presc_eff;
  logic        tick;

  assign presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  assign tick      = (timer_q == 19'd0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    presc_d  = presc_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovr_d    = 1'b0;
    ferr_d   = 1'b0;

    // Beat consumed; a commit below may re-assert it in the same cycle.
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rxd_prev_q && !rxd_s_q) begin
          presc_d = presc_eff;
          // Half a bit period lands the start sample mid-bit.
          timer_d = {1'b0, presc_eff, 2'b00} - 19'd1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rxd_s_q) begin
            state_d = IDLE;             // glitch, not a real start bit
          end else begin
            timer_d = {presc_q, 3'b000} - 19'd1;
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
          timer_d = {presc_q, 3'b000} - 19'd1;
          if (bit_q == CW'(DATA_WIDTH - 1)) state_d = STOP;
          else                              bit_d   = bit_q + CW'(1);
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxd_s_q) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
            // Old beat still pending and not taken this cycle: it is lost.
            ovr_d    = tvalid_q && !m_axis_tready;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not taken as a start.
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      timer_q    <= '0;
      presc_q    <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;

endmodule
